// File: rtl/micro_pkg.sv
// Shared constants, types and field helpers for the next-address control stage.
package micro_pkg;

  localparam int UADDR_W     = 12;
  localparam int CNT_W       = 8;
  localparam int STACK_DEPTH = 4;
  localparam int UWORD_W     = 28;
  localparam int COND_W      = 7;

  // Bit positions of the sequencing slice inside a microword.
  localparam int NC_LSB       = 0;
  localparam int COND_SEL_LSB = 3;
  localparam int COND_POL_BIT = 6;
  localparam int LD_CNT_BIT   = 7;
  localparam int BR_ADDR_LSB  = 8;
  localparam int CNT_VAL_LSB  = 20;

  typedef enum logic [1:0] {
    SEQ_NEXT = 2'd0,
    SEQ_JUMP = 2'd1,
    SEQ_CALL = 2'd2,
    SEQ_RET  = 2'd3
  } seq_op_e;

  typedef enum logic [2:0] {
    NC_CONT  = 3'd0,
    NC_CJUMP = 3'd1,
    NC_CCALL = 3'd2,
    NC_CRET  = 3'd3,
    NC_LOOP  = 3'd4,
    NC_WAIT  = 3'd5,
    NC_RSV6  = 3'd6,
    NC_RSV7  = 3'd7
  } next_ctl_e;

  typedef struct packed {
    logic [CNT_W-1:0]   cnt_val;
    logic [UADDR_W-1:0] br_addr;
    logic               ld_cnt;
    logic               cond_pol;
    logic [2:0]         cond_sel;
    next_ctl_e          next_ctl;
  } uword_t;

  // Split a raw microword slice into its named fields.
  function automatic uword_t unpack_uword(input logic [UWORD_W-1:0] raw);
    uword_t w;
    w.next_ctl = next_ctl_e'(raw[NC_LSB +: 3]);
    w.cond_sel = raw[COND_SEL_LSB +: 3];
    w.cond_pol = raw[COND_POL_BIT];
    w.ld_cnt   = raw[LD_CNT_BIT];
    w.br_addr  = raw[BR_ADDR_LSB +: UADDR_W];
    w.cnt_val  = raw[CNT_VAL_LSB +: CNT_W];
    return w;
  endfunction

  // Selected condition flag; select 0 is the constant-true condition.
  function automatic logic cond_test(input logic [2:0] sel, input logic [COND_W:1] flags);
    logic [COND_W:0] ext;
    ext = {flags, 1'b1};
    return ext[sel];
  endfunction

endpackage

// File: rtl/micro_loop_counter.sv
// Loop counter: load has priority over decrement, decrement stops at zero.
module micro_loop_counter
  import micro_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load wins, otherwise decrement when asked and non-zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != CNT_ZERO)) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == CNT_ZERO);

endmodule

// File: rtl/micro_next_addr.sv
// Next-address control stage: microprogram pipeline register, branch decode,
// loop counter, wait-on-condition and call-depth/illegal-code error tracking.
module micro_next_addr
  import micro_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [UWORD_W-1:0] uword,
  input  logic [UADDR_W-1:0] seq_y,
  input  logic [COND_W:1]    cond_in,
  output logic [1:0]         seq_op,
  output logic [UADDR_W-1:0] seq_din,
  output logic [UADDR_W-1:0] upc,
  output logic [CNT_W-1:0]   cnt,
  output logic               stk_err,
  output logic               ill_op
);

  localparam logic [2:0] DEPTH_MAX  = 3'(STACK_DEPTH);
  localparam logic [2:0] DEPTH_ZERO = 3'd0;
  localparam logic [2:0] DEPTH_ONE  = 3'd1;

  logic [UWORD_W-1:0] pr_q;
  logic [UADDR_W-1:0] upc_q;
  logic [2:0]         depth_q;
  logic [2:0]         depth_d;
  logic               stk_err_q;
  logic               stk_err_d;
  logic               ill_op_q;
  logic               ill_op_d;

  uword_t             pr_s;
  seq_op_e            op_s;
  logic [UADDR_W-1:0] seq_din_s;
  logic               taken_s;
  logic               loop_dec_s;
  logic               ill_seen_s;
  logic               cnt_zero_s;
  logic [CNT_W-1:0]   cnt_s;

  assign pr_s    = unpack_uword(pr_q);
  assign taken_s = cond_test(pr_s.cond_sel, cond_in) ^ pr_s.cond_pol;

  // Pipeline register: capture the fetched word and its address every cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      pr_q  <= {UWORD_W{1'b0}};
      upc_q <= {UADDR_W{1'b0}};
    end else begin
      pr_q  <= uword;
      upc_q <= seq_y;
    end
  end

  // Decode the executing word into a sequencer op and branch address.
  always_comb begin
    op_s       = SEQ_NEXT;
    loop_dec_s = 1'b0;
    ill_seen_s = 1'b0;
    case (pr_s.next_ctl)
      NC_CONT:  op_s = SEQ_NEXT;
      NC_CJUMP: op_s = taken_s ? SEQ_JUMP : SEQ_NEXT;
      NC_CCALL: op_s = taken_s ? SEQ_CALL : SEQ_NEXT;
      NC_CRET:  op_s = taken_s ? SEQ_RET  : SEQ_NEXT;
      NC_LOOP: begin
        if (!cnt_zero_s) begin
          op_s       = SEQ_JUMP;
          loop_dec_s = 1'b1;
        end else begin
          op_s       = SEQ_NEXT;
        end
      end
      // Not yet satisfied: jump back to our own address to refetch this word.
      NC_WAIT:  op_s = taken_s ? SEQ_NEXT : SEQ_JUMP;
      NC_RSV6, NC_RSV7: begin
        op_s       = SEQ_NEXT;
        ill_seen_s = 1'b1;
      end
      default: begin
        op_s       = SEQ_NEXT;
        ill_seen_s = 1'b1;
      end
    endcase
    seq_din_s = (pr_s.next_ctl == NC_WAIT) ? upc_q : pr_s.br_addr;
  end

  // Track call depth; over/underflow is flagged but the op still goes out.
  always_comb begin
    depth_d   = depth_q;
    stk_err_d = stk_err_q;
    ill_op_d  = ill_op_q | ill_seen_s;
    case (op_s)
      SEQ_CALL: begin
        if (depth_q == DEPTH_MAX) begin
          stk_err_d = 1'b1;
        end else begin
          depth_d = depth_q + DEPTH_ONE;
        end
      end
      SEQ_RET: begin
        if (depth_q == DEPTH_ZERO) begin
          stk_err_d = 1'b1;
        end else begin
          depth_d = depth_q - DEPTH_ONE;
        end
      end
      default: depth_d = depth_q;
    endcase
  end

  // Depth and sticky error flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      depth_q   <= DEPTH_ZERO;
      stk_err_q <= 1'b0;
      ill_op_q  <= 1'b0;
    end else begin
      depth_q   <= depth_d;
      stk_err_q <= stk_err_d;
      ill_op_q  <= ill_op_d;
    end
  end

  micro_loop_counter u_loop_counter (
    .clock      (clock),
    .reset      (reset),
    .load_i     (pr_s.ld_cnt),
    .load_val_i (pr_s.cnt_val),
    .dec_i      (loop_dec_s),
    .cnt_o      (cnt_s),
    .zero_o     (cnt_zero_s)
  );

  assign seq_op  = op_s;
  assign seq_din = seq_din_s;
  assign upc     = upc_q;
  assign cnt     = cnt_s;
  assign stk_err = stk_err_q;
  assign ill_op  = ill_op_q;

endmodule

// File: tb/tb_micro_next_addr.sv
// Bench for micro_next_addr: a behavioural sequencer + ROM closes the loop,
// and a spec-level model of the stage predicts every output each cycle.
module tb_micro_next_addr;

  logic        clock = 1'b0;
  logic        reset;
  logic [27:0] uword;
  logic [11:0] seq_y;
  logic [7:1]  cond_in;
  logic [1:0]  seq_op;
  logic [11:0] seq_din;
  logic [11:0] upc;
  logic [7:0]  cnt;
  logic        stk_err;
  logic        ill_op;

  always #5 clock = ~clock;

  micro_next_addr dut (
    .clock   (clock),
    .reset   (reset),
    .uword   (uword),
    .seq_y   (seq_y),
    .cond_in (cond_in),
    .seq_op  (seq_op),
    .seq_din (seq_din),
    .upc     (upc),
    .cnt     (cnt),
    .stk_err (stk_err),
    .ill_op  (ill_op)
  );

  logic [27:0] rom [0:4095];

  // reference model state
  logic [27:0] m_pr;
  logic [11:0] m_upc;
  logic [7:0]  m_cnt;
  int          m_depth;
  logic        m_stk;
  logic        m_ill;
  logic [11:0] sq_pc;
  logic [11:0] sq_stack [$];
  logic [11:0] cur_y;
  logic [1:0]  exp_op;
  logic [11:0] exp_din;

  logic [35:0] dut_vec;
  logic [35:0] mdl_vec;
  assign dut_vec = {seq_op, seq_din, upc, cnt, stk_err, ill_op};

  int compared   = 0;
  int mismatched = 0;

  function automatic logic [27:0] mk(input int nc, input int sel, input int pol,
                                     input int ld, input int br, input int cv);
    logic [27:0] w;
    w        = 28'd0;
    w[2:0]   = nc[2:0];
    w[5:3]   = sel[2:0];
    w[6]     = pol[0];
    w[7]     = ld[0];
    w[19:8]  = br[11:0];
    w[27:20] = cv[7:0];
    return w;
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = mk(0, 0, 0, 0, int'($urandom_range(0, 4095)), 0);
  endtask

  // Predict this cycle's op/din, let the sequencer pick the address, drive ROM data.
  task automatic prep();
    int   code;
    int   sel;
    logic test;
    logic taken;
    code  = int'(m_pr[2:0]);
    sel   = int'(m_pr[5:3]);
    test  = (sel == 0) ? 1'b1 : cond_in[sel];
    taken = test ^ m_pr[6];
    exp_op = 2'd0;
    if (code == 1 && taken)          exp_op = 2'd1;
    else if (code == 2 && taken)     exp_op = 2'd2;
    else if (code == 3 && taken)     exp_op = 2'd3;
    else if (code == 4 && m_cnt != 0) exp_op = 2'd1;
    else if (code == 5 && !taken)    exp_op = 2'd1;
    exp_din = (code == 5) ? m_upc : m_pr[19:8];
    if (reset) cur_y = 12'd0;
    else if (exp_op == 2'd0) cur_y = sq_pc;
    else if (exp_op == 2'd3) cur_y = (sq_stack.size() > 0) ? sq_stack[$] : 12'd0;
    else cur_y = exp_din;
    seq_y   = cur_y;
    uword   = rom[cur_y];
    mdl_vec = {exp_op, exp_din, m_upc, m_cnt, m_stk, m_ill};
    #1;
  endtask

  // Clock edge: advance the model by the spec's end-of-cycle rules.
  task automatic tick();
    @(posedge clock);
    if (reset) begin
      m_pr = 28'd0; m_upc = 12'd0; m_cnt = 8'd0; m_depth = 0;
      m_stk = 1'b0; m_ill = 1'b0; sq_pc = 12'd0; sq_stack.delete();
    end else begin
      if (m_pr[7]) m_cnt = m_pr[27:20];
      else if (m_pr[2:0] == 3'd4 && m_cnt != 0) m_cnt = m_cnt - 8'd1;
      if (exp_op == 2'd2) begin
        if (m_depth == 4) m_stk = 1'b1; else m_depth++;
        sq_stack.push_back(sq_pc);
      end
      if (exp_op == 2'd3) begin
        if (m_depth == 0) m_stk = 1'b1; else m_depth--;
        if (sq_stack.size() > 0) void'(sq_stack.pop_back());
      end
      if (m_pr[2:0] >= 3'd6) m_ill = 1'b1;
      m_pr  = rom[cur_y];
      m_upc = cur_y;
      sq_pc = cur_y + 12'd1;
    end
    #1;
  endtask

  task automatic apply_reset();
    reset   = 1'b1;
    cond_in = 7'd0;
    repeat (2) begin prep(); tick(); end
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_rom();
    rom[0] = mk(6, 0, 0, 1, 0, 8'h55);
    apply_reset();
    repeat (3) begin
      prep();
      if (dut_vec !== mdl_vec) begin mismatched++; $display("FAIL pre_reset: dut %h model %h", dut_vec, mdl_vec); end
      compared++;
      tick();
    end
    reset = 1'b1;
    prep(); tick(); prep();
    if (dut_vec !== 36'd0) begin mismatched++; $display("FAIL reset_state: dut %h want 0", dut_vec); end
    compared++;
    tick();
    reset = 1'b0;
    prep();
    if (dut_vec !== 36'd0) begin mismatched++; $display("FAIL post_reset: dut %h want 0", dut_vec); end
    compared++;
    tick(); prep();
    if (upc !== 12'd0) begin mismatched++; $display("FAIL resume_at_0: upc %h want 000", upc); end
    compared++;
  endtask

  task automatic test_cont();
    clear_rom();
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      cond_in = 7'($urandom);
      prep();
      if (dut_vec !== mdl_vec) begin mismatched++; $display("FAIL cont[%0d]: dut %h model %h", i, dut_vec, mdl_vec); end
      compared++;
      if (i >= 1) begin
        if (upc !== 12'(i - 1) || seq_op !== 2'd0) begin
          mismatched++; $display("FAIL cont_step[%0d]: upc %h op %0d want upc %h op 0", i, upc, seq_op, 12'(i - 1));
        end
        compared++;
      end
      tick();
    end
  endtask

  task automatic test_cjump(input logic flag);
    logic after;
    clear_rom();
    rom[2] = mk(1, 3, 0, 0, 12'h040, 0);
    apply_reset();
    after = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cond_in = 7'($urandom);
      cond_in[3] = flag;
      prep();
      if (dut_vec !== mdl_vec) begin mismatched++; $display("FAIL cjump[%0d]: dut %h model %h", i, dut_vec, mdl_vec); end
      compared++;
      if (after) begin
        if (upc !== (flag ? 12'h040 : 12'd3)) begin mismatched++; $display("FAIL cjump_target: upc %h flag %b", upc, flag); end
        compared++;
        after = 1'b0;
      end
      if (m_upc == 12'd2 && i > 0) begin
        if (seq_op !== (flag ? 2'd1 : 2'd0) || seq_din !== 12'h040) begin
          mismatched++; $display("FAIL cjump_op: op %0d din %h flag %b want din 040", seq_op, seq_din, flag);
        end
        compared++;
        after = 1'b1;
      end
      tick();
    end
  endtask

  task automatic test_loop();
    int body;
    int seen [$];
    clear_rom();
    rom[0] = mk(0, 0, 0, 1, 0, 3);
    rom[2] = mk(4, 0, 0, 0, 1, 0);
    apply_reset();
    body = 0;
    for (int i = 0; i < 20; i++) begin
      cond_in = 7'($urandom);
      prep();
      if (dut_vec !== mdl_vec) begin mismatched++; $display("FAIL loop[%0d]: dut %h model %h", i, dut_vec, mdl_vec); end
      compared++;
      if (i > 0 && upc == 12'd1) body++;
      if (i > 0 && upc == 12'd2) seen.push_back(int'(cnt));
      tick();
    end
    if (body !== 4) begin mismatched++; $display("FAIL loop_body: ran %0d want 4", body); end
    compared++;
    if (seen.size() != 4) begin
      mismatched++; $display("FAIL loop_cnt_len: %0d loop executions want 4", seen.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (seen[k] !== 3 - k) begin mismatched++; $display("FAIL loop_cnt[%0d]: %0d want %0d", k, seen[k], 3 - k); end
      end
    end
    compared++;
  endtask

  task automatic test_wait();
    int   waits;
    logic released;
    clear_rom();
    rom[1] = mk(5, 2, 0, 0, 12'h777, 0);
    apply_reset();
    waits    = 0;
    released = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cond_in = 7'd0;
      if (m_upc == 12'd1 && i > 0 && waits >= 5) cond_in[2] = 1'b1;
      prep();
      if (dut_vec !== mdl_vec) begin mismatched++; $display("FAIL wait[%0d]: dut %h model %h", i, dut_vec, mdl_vec); end
      compared++;
      if (released) begin
        if (upc !== 12'd2) begin mismatched++; $display("FAIL wait_advance: upc %h want 002", upc); end
        compared++;
        released = 1'b0;
      end else if (m_upc == 12'd1 && i > 0) begin
        if (waits < 5) begin
          if (seq_op !== 2'd1 || seq_din !== 12'd1 || upc !== 12'd1) begin
            mismatched++; $display("FAIL wait_hold: op %0d din %h upc %h want op 1 din 001", seq_op, seq_din, upc);
          end
          waits++;
        end else begin
          if (seq_op !== 2'd0) begin mismatched++; $display("FAIL wait_release: op %0d want 0", seq_op); end
          released = 1'b1;
          waits    = 0;
        end
        compared++;
      end
      tick();
    end
  endtask

  task automatic test_stack();
    clear_rom();
    rom[12'h000] = mk(2, 0, 0, 0, 12'h010, 0);
    rom[12'h010] = mk(2, 0, 0, 0, 12'h020, 0);
    rom[12'h020] = mk(2, 0, 0, 0, 12'h030, 0);
    rom[12'h030] = mk(2, 0, 0, 0, 12'h040, 0);
    rom[12'h040] = mk(2, 0, 0, 0, 12'h050, 0);
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      cond_in = 7'($urandom);
      prep();
      if (dut_vec !== mdl_vec) begin mismatched++; $display("FAIL stack[%0d]: dut %h model %h", i, dut_vec, mdl_vec); end
      compared++;
      if (m_upc == 12'h040) begin
        if (stk_err !== 1'b0) begin mismatched++; $display("FAIL stack_four_ok: stk_err %b want 0", stk_err); end
        compared++;
      end
      tick();
    end
    prep();
    if (stk_err !== 1'b1) begin mismatched++; $display("FAIL stack_overflow: stk_err %b want 1", stk_err); end
    compared++;
    rom[12'h000] = mk(3, 0, 0, 0, 0, 0);
    apply_reset();
    prep();
    if (stk_err !== 1'b0) begin mismatched++; $display("FAIL stack_reset: stk_err %b want 0", stk_err); end
    compared++;
    repeat (4) tick_and_prep();
    if (stk_err !== 1'b1) begin mismatched++; $display("FAIL stack_underflow: stk_err %b want 1", stk_err); end
    compared++;
  endtask

  task automatic tick_and_prep();
    tick();
    prep();
  endtask

  task automatic test_illegal();
    clear_rom();
    rom[1] = mk(6, 0, 0, 0, int'($urandom_range(0, 4095)), 0);
    rom[2] = mk(7, 0, 0, 0, int'($urandom_range(0, 4095)), 0);
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      cond_in = 7'($urandom);
      prep();
      if (dut_vec !== mdl_vec) begin mismatched++; $display("FAIL illegal[%0d]: dut %h model %h", i, dut_vec, mdl_vec); end
      compared++;
      if (i > 0 && m_upc >= 12'd2) begin
        if (ill_op !== 1'b1) begin mismatched++; $display("FAIL ill_sticky[%0d]: ill_op %b want 1", i, ill_op); end
        compared++;
      end
      tick();
    end
    apply_reset();
    prep();
    if (ill_op !== 1'b0) begin mismatched++; $display("FAIL ill_reset: ill_op %b want 0", ill_op); end
    compared++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 4096; i++) rom[i] = 28'($urandom);
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      reset   = ($urandom_range(0, 63) == 0);
      cond_in = 7'($urandom);
      prep();
      if (dut_vec !== mdl_vec) begin mismatched++; $display("FAIL random[%0d]: dut %h model %h", i, dut_vec, mdl_vec); end
      compared++;
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    cond_in = 7'd0;
    uword   = 28'd0;
    seq_y   = 12'd0;
    test_reset();
    test_cont();
    test_cjump(1'b1);
    test_cjump(1'b0);
    test_loop();
    test_wait();
    test_stack();
    test_illegal();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
